// File: rtl/tile_writer_if.sv
// Request and LCD-bus bundle for tile_writer: control/status plus the 8080-style wr/dcx/D pins.
interface tile_writer_if #(
   parameter int unsigned GRID_BITS = 4
);
   logic                 init;
   logic                 start;
   logic [GRID_BITS-1:0] x;
   logic [GRID_BITS-1:0] y;
   logic [2:0]           obj_code;
   logic                 busy;
   logic                 done;
   logic                 wr;
   logic                 dcx;
   logic [7:0]           D;

   modport master (
      output init, start, x, y, obj_code,
      input  busy, done, wr, dcx, D
   );

   modport slave (
      input  init, start, x, y, obj_code,
      output busy, done, wr, dcx, D
   );
endinterface

// File: rtl/tile_writer.sv
// Draws one TILE_PX x TILE_PX tile (or runs panel init) over an 8-bit 8080-style LCD bus.
// Define TILE_BORDER_EN to paint the outermost pixel ring of each tile black.
module tile_writer #(
   parameter int unsigned GRID_BITS = 4,
   parameter int unsigned TILE_PX   = 16,
   parameter int unsigned WR_DIV    = 2,
   parameter int unsigned INIT_WAIT = 1024
) (
   input logic          clk,
   input logic          rst,
   tile_writer_if.slave bus
);

   localparam int unsigned TP_LOG   = $clog2(TILE_PX);
   localparam int unsigned PIX_W    = 2 * TP_LOG + 1;
   localparam int unsigned PIX_LAST = TILE_PX * TILE_PX - 1;
   localparam int unsigned CNT_MAX  = (INIT_WAIT > WR_DIV) ? INIT_WAIT : WR_DIV;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned STEP_W   = 4;
   localparam int unsigned STEP_PIX = 11;
   localparam int unsigned STEP_INIT_LAST = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BYTE_LO,
      S_BYTE_HI,
      S_DELAY,
      S_FIN
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [STEP_W-1:0]    step, step_n;
   logic                 half, half_n;
   logic [PIX_W-1:0]     pix, pix_n;
   logic                 mode_init, mode_n;
   logic [GRID_BITS-1:0] x_q, x_n, y_q, y_n;
   logic [2:0]           obj_q, obj_n;
   logic                 wr_q, wr_n, dcx_q, dcx_n, busy_q, busy_n, done_q, done_n;
   logic [7:0]           d_q, d_n;
   logic [15:0]          colour;
   logic                 last_byte;
   logic [15:0]          xs_c, xe_c, ys_c, ye_c;
`ifdef TILE_BORDER_EN
   logic [TP_LOG-1:0]    row, col;
`endif

   assign xs_c = 16'(x_q) << TP_LOG;
   assign xe_c = xs_c + 16'(TILE_PX - 1);
   assign ys_c = 16'(y_q) << TP_LOG;
   assign ye_c = ys_c + 16'(TILE_PX - 1);

   assign bus.wr   = wr_q;
   assign bus.dcx  = dcx_q;
   assign bus.D    = d_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

   function automatic logic [15:0] palette(input logic [2:0] code);
      case (code)
         3'd0:    palette = 16'h0000;
         3'd1:    palette = 16'hFFFF;
         3'd2:    palette = 16'hF800;
         3'd3:    palette = 16'h07E0;
         3'd4:    palette = 16'h001F;
         3'd5:    palette = 16'hFFE0;
         3'd6:    palette = 16'h07FF;
         default: palette = 16'hF81F;
      endcase
   endfunction

   // {dcx, byte} for a given position in the init or tile sequence
   function automatic logic [8:0] seq_byte(
      input logic              is_init,
      input logic [STEP_W-1:0] s,
      input logic              h,
      input logic [15:0]       col_w,
      input logic [15:0]       xs,
      input logic [15:0]       xe,
      input logic [15:0]       ys,
      input logic [15:0]       ye
   );
      if (is_init) begin
         case (s)
            4'd0:    seq_byte = {1'b0, 8'h01};
            4'd1:    seq_byte = {1'b0, 8'h11};
            4'd2:    seq_byte = {1'b0, 8'h3A};
            4'd3:    seq_byte = {1'b1, 8'h55};
            default: seq_byte = {1'b0, 8'h29};
         endcase
      end else begin
         case (s)
            4'd0:    seq_byte = {1'b0, 8'h2A};
            4'd1:    seq_byte = {1'b1, xs[15:8]};
            4'd2:    seq_byte = {1'b1, xs[7:0]};
            4'd3:    seq_byte = {1'b1, xe[15:8]};
            4'd4:    seq_byte = {1'b1, xe[7:0]};
            4'd5:    seq_byte = {1'b0, 8'h2B};
            4'd6:    seq_byte = {1'b1, ys[15:8]};
            4'd7:    seq_byte = {1'b1, ys[7:0]};
            4'd8:    seq_byte = {1'b1, ye[15:8]};
            4'd9:    seq_byte = {1'b1, ye[7:0]};
            4'd10:   seq_byte = {1'b0, 8'h2C};
            default: seq_byte = {1'b1, h ? col_w[7:0] : col_w[15:8]};
         endcase
      end
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         step      <= '0;
         half      <= 1'b0;
         pix       <= '0;
         mode_init <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         obj_q     <= '0;
         wr_q      <= 1'b1;
         dcx_q     <= 1'b1;
         d_q       <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         step      <= step_n;
         half      <= half_n;
         pix       <= pix_n;
         mode_init <= mode_n;
         x_q       <= x_n;
         y_q       <= y_n;
         obj_q     <= obj_n;
         wr_q      <= wr_n;
         dcx_q     <= dcx_n;
         d_q       <= d_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      step_n  = step;
      half_n  = half;
      pix_n   = pix;
      mode_n  = mode_init;
      x_n     = x_q;
      y_n     = y_q;
      obj_n   = obj_q;
      dcx_n   = dcx_q;
      d_n     = d_q;
      colour  = 16'h0000;

      last_byte = mode_init ? (step == STEP_W'(STEP_INIT_LAST))
                            : (step == STEP_W'(STEP_PIX) && half && pix == PIX_W'(PIX_LAST));

      case (state)
         S_IDLE: begin
            // init wins over a simultaneous start
            if (bus.init || bus.start) begin
               mode_n  = bus.init;
               x_n     = bus.x;
               y_n     = bus.y;
               obj_n   = bus.obj_code;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            step_n  = '0;
            half_n  = 1'b0;
            pix_n   = '0;
            cnt_n   = '0;
            state_n = S_BYTE_LO;
         end
         S_BYTE_LO: begin
            if (cnt == CNT_W'(WR_DIV - 1)) begin
               cnt_n   = '0;
               state_n = S_BYTE_HI;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_BYTE_HI: begin
            if (cnt == CNT_W'(WR_DIV - 1)) begin
               cnt_n = '0;
               if (last_byte) begin
                  state_n = S_FIN;
               end else begin
                  if (mode_init || step < STEP_W'(STEP_PIX)) begin
                     step_n = step + STEP_W'(1);
                  end else if (half) begin
                     half_n = 1'b0;
                     pix_n  = pix + PIX_W'(1);
                  end else begin
                     half_n = 1'b1;
                  end
                  // SWRESET and SLPOUT need the panel to settle before the next byte
                  state_n = (mode_init && step <= STEP_W'(1)) ? S_DELAY : S_BYTE_LO;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_DELAY: begin
            if (cnt == CNT_W'(INIT_WAIT - 1)) begin
               cnt_n   = '0;
               state_n = S_BYTE_LO;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_FIN: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

`ifdef TILE_BORDER_EN
      row    = TP_LOG'(pix_n >> TP_LOG);
      col    = TP_LOG'(pix_n);
      colour = (row == '0 || row == TP_LOG'(TILE_PX - 1) ||
                col == '0 || col == TP_LOG'(TILE_PX - 1)) ? 16'h0000 : palette(obj_q);
`else
      colour = palette(obj_q);
`endif

      // D/dcx only move on the edge that starts a new low phase
      if (state_n == S_BYTE_LO && state != S_BYTE_LO) begin
         {dcx_n, d_n} = seq_byte(mode_n, step_n, half_n, colour, xs_c, xe_c, ys_c, ye_c);
      end

      wr_n   = (state_n != S_BYTE_LO);
      busy_n = (state_n == S_BYTE_LO) || (state_n == S_BYTE_HI) ||
               (state_n == S_DELAY)   || (state_n == S_FIN);
      done_n = (state_n == S_FIN);
   end

endmodule

// File: tb/tb_tile_writer.sv
// Bench for tile_writer: two parameter sets, vector table, hand sequences and random tiles vs a byte-stream model.
module tb_tile_writer;

   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tile_writer_if #(.GRID_BITS(4)) bus_a ();
   tile_writer_if #(.GRID_BITS(4)) bus_b ();

   tile_writer #(.GRID_BITS(4), .TILE_PX(4), .WR_DIV(1), .INIT_WAIT(IW)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   tile_writer #(.GRID_BITS(4), .TILE_PX(16), .WR_DIV(2), .INIT_WAIT(IW)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      int d; bit ini; bit st; int x; int y; int ob; int poke1; int poke2;
      int len; int ncmd; int dur;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt [2];
   int done_cyc [2];
   int busy_rise [2];
   int dstab [2];
   bit wr_p [2];
   bit busy_p [2];
   logic [8:0] lowv [2];
   logic [8:0] cap0 [$];
   logic [8:0] cap1 [$];
   int rise0 [$];
   int rise1 [$];
   logic [8:0] got [$];
   logic [8:0] exp_q [$];
   int got_r [$];
   int pal [8] = '{'h0000, 'hFFFF, 'hF800, 'h07E0, 'h001F, 'hFFE0, 'h07FF, 'hF81F};
   logic [7:0] lit_a [13] = '{8'h2A, 8'h00, 8'h08, 8'h00, 8'h0B, 8'h2B, 8'h00,
                              8'h04, 8'h00, 8'h07, 8'h2C, 8'hF8, 8'h00};
   vec_t vt [7];

   wire [11:0] sig0 = {bus_a.busy, bus_a.done, bus_a.wr, bus_a.dcx, bus_a.D};
   wire [11:0] sig1 = {bus_b.busy, bus_b.done, bus_b.wr, bus_b.dcx, bus_b.D};

   always @(posedge clk) cyc <= cyc + 1;

   // bus monitor: bytes at wr rising edges, done pulses, busy rise, data stability while wr low
   always @(negedge clk) begin
      logic [11:0] s;
      for (int d = 0; d < 2; d++) begin
         s = (d == 0) ? sig0 : sig1;
         if (rst) begin
            wr_p[d] = 1'b1;
            busy_p[d] = 1'b0;
         end else begin
            if (!wr_p[d] && s[9]) begin
               if (s[8:0] != lowv[d]) dstab[d]++;
               if (d == 0) begin cap0.push_back(s[8:0]); rise0.push_back(cyc); end
               else        begin cap1.push_back(s[8:0]); rise1.push_back(cyc); end
            end
            if (!wr_p[d] && !s[9] && s[8:0] != lowv[d]) dstab[d]++;
            lowv[d] = s[8:0];
            if (s[11] && !busy_p[d]) busy_rise[d] = cyc;
            if (s[10]) begin done_cnt[d]++; done_cyc[d] = cyc; end
            wr_p[d] = s[9];
            busy_p[d] = s[11];
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s act=%0d req=%0d", nm, act, req);
      end
   endtask

   task automatic set_in(input int d, input bit ini, input bit st, input int x, input int y, input int ob);
      if (d == 0) begin
         bus_a.init = ini; bus_a.start = st; bus_a.x = 4'(x); bus_a.y = 4'(y); bus_a.obj_code = 3'(ob);
      end else begin
         bus_b.init = ini; bus_b.start = st; bus_b.x = 4'(x); bus_b.y = 4'(y); bus_b.obj_code = 3'(ob);
      end
   endtask

   task automatic push(input bit dcx, input int b);
      exp_q.push_back({dcx, 8'(b)});
   endtask

   // expected byte stream straight from the command/pixel rules
   task automatic build_exp(input int d, input bit ini, input int x, input int y, input int ob);
      int tp, c, w[4];
      bit border;
      tp = (d == 0) ? 4 : 16;
      exp_q.delete();
      if (ini) begin
         push(0, 'h01); push(0, 'h11); push(0, 'h3A); push(1, 'h55); push(0, 'h29);
      end else begin
         w[0] = x * tp; w[1] = x * tp + tp - 1; w[2] = y * tp; w[3] = y * tp + tp - 1;
         push(0, 'h2A);
         for (int i = 0; i < 2; i++) begin push(1, w[i] / 256); push(1, w[i] % 256); end
         push(0, 'h2B);
         for (int i = 2; i < 4; i++) begin push(1, w[i] / 256); push(1, w[i] % 256); end
         push(0, 'h2C);
         for (int r = 0; r < tp; r++)
            for (int k = 0; k < tp; k++) begin
               border = (r == 0 || r == tp - 1 || k == 0 || k == tp - 1);
               c = pal[ob];
`ifdef TILE_BORDER_EN
               if (border) c = 0;
`endif
               push(1, c / 256); push(1, c % 256);
            end
      end
   endtask

   task automatic run_seq(input string id, input vec_t v);
      int base, wd, nc, mis, sp, exp_gap;
      bit seen;
      logic [8:0] gv, ev;
      wd = (v.d == 0) ? 1 : 2;
      build_exp(v.d, v.ini, v.x, v.y, v.ob);
      if (v.d == 0) begin cap0.delete(); rise0.delete(); end
      else          begin cap1.delete(); rise1.delete(); end
      dstab[v.d] = 0;
      base = done_cnt[v.d];
      @(negedge clk); #1;
      set_in(v.d, v.ini, v.st, v.x, v.y, v.ob);
      seen = 0;
      for (int k = 1; k <= 6000 && !seen; k++) begin
         @(negedge clk); #1;
         if (k == v.poke1)      set_in(v.d, 0, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
         else if (k == v.poke2) set_in(v.d, 1, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
         else                   set_in(v.d, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
         if (done_cnt[v.d] != base) seen = 1;
      end
      chk({id, " done_seen"}, int'(seen), 1);
      repeat (8) @(negedge clk);
      #1;
      if (v.d == 0) begin got = cap0; got_r = rise0; end
      else          begin got = cap1; got_r = rise1; end
      chk({id, " done_once"}, done_cnt[v.d] - base, 1);
      chk({id, " len"}, got.size(), v.len);
      mis = -1; gv = '0; ev = '0;
      for (int j = 0; j < exp_q.size(); j++)
         if (mis < 0 && (j >= got.size() || got[j] != exp_q[j])) begin
            mis = j; ev = exp_q[j];
            if (j < got.size()) gv = got[j];
         end
      chk($sformatf("%s bytes got=%03h exp=%03h at", id, gv, ev), mis, -1);
      nc = 0;
      foreach (got[j]) if (!got[j][8]) nc++;
      chk({id, " cmd_count"}, nc, v.ncmd);
      chk({id, " done_latency"}, done_cyc[v.d] - busy_rise[v.d], v.dur);
      sp = 0;
      for (int j = 1; j < got_r.size(); j++) begin
         exp_gap = 2 * wd + ((v.ini && j - 1 <= 1) ? IW : 0);
         if (got_r[j] - got_r[j-1] != exp_gap) sp++;
      end
      chk({id, " strobe_spacing"}, sp, 0);
      chk({id, " data_stable"}, dstab[v.d], 0);
      chk({id, " idle_after"}, int'(v.d == 0 ? sig0[11:10] : sig1[11:10]), 0);
   endtask

   initial begin
      vec_t rv;
      int mm;
      vt[0] = '{0, 1'b0, 1'b1,  2,  1, 2,  0,  0,  43, 3,   86};
      vt[1] = '{0, 1'b1, 1'b0,  0,  0, 0,  4, 14,   5, 4,   26};
      vt[2] = '{0, 1'b1, 1'b1,  1,  2, 3,  0,  0,   5, 4,   26};
      vt[3] = '{1, 1'b0, 1'b1, 15, 15, 7, 30, 40, 523, 3, 2092};
      vt[4] = '{0, 1'b0, 1'b1,  3,  3, 1,  5,  0,  43, 3,   86};
      vt[5] = '{1, 1'b1, 1'b0,  0,  0, 0,  3, 20,   5, 4,   36};
      vt[6] = '{1, 1'b0, 1'b1,  0,  0, 0,  0,  0, 523, 3, 2092};

      set_in(0, 0, 0, 0, 0, 0);
      set_in(1, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_a", int'(sig0), 'h300);
      chk("reset_b", int'(sig1), 'h300);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_seq($sformatf("v%0d", i), vt[i]);
         if (i == 0) begin
            mm = 0;
            for (int j = 0; j < 13; j++) if (j >= got.size() || got[j][7:0] != lit_a[j]) mm++;
            chk("tile_a_literal", mm, 0);
         end
         if (i == 3) begin
            mm = 0;
            for (int j = 0; j < 2; j++) begin
               if (got.size() < 13) mm++;
               else if ({got[1+5*j][7:0], got[2+5*j][7:0], got[3+5*j][7:0], got[4+5*j][7:0]} != 32'h00F0_00FF) mm++;
            end
            if (got.size() >= 13 && {got[11][7:0], got[12][7:0]} != 16'hF81F) mm++;
            chk("max_coord_literal", mm, 0);
         end
      end

      // reset in the middle of a tile, then a fresh tile must start from 0x2A
      @(negedge clk); #1;
      set_in(0, 0, 1, 3, 2, 5);
      @(negedge clk); #1;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (20) @(negedge clk);
      #1;
      chk("rst_mid_busy", int'(sig0[11]), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_async", int'(sig0), 'h300);
      @(negedge clk); #1;
      rst = 1'b0;
      rv = '{0, 1'b0, 1'b1, 1, 1, 3, 0, 0, 43, 3, 86};
      run_seq("after_rst", rv);
      chk("after_rst_first", got.size() > 0 ? int'(got[0]) : -1, 'h02A);

      for (int r = 0; r < 10; r++) begin
         rv.d = r % 2;
         rv.ini = ($urandom_range(0, 3) == 0);
         rv.st = 1'b1;
         rv.x = $urandom_range(0, 15);
         rv.y = $urandom_range(0, 15);
         rv.ob = $urandom_range(0, 7);
         rv.poke1 = $urandom_range(3, 20);
         rv.poke2 = 0;
         rv.len = rv.ini ? 5 : 11 + 2 * ((rv.d == 0) ? 16 : 256);
         rv.ncmd = rv.ini ? 4 : 3;
         rv.dur = rv.ini ? 5 * 2 * (rv.d + 1) + 2 * IW : rv.len * 2 * (rv.d + 1);
         run_seq($sformatf("rnd%0d", r), rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tile_writer.md
Name: tile_writer

Overview:
- Parametrised successor to the team's single-pixel LCD updater.
- Draws one square tile of TILE_PX x TILE_PX pixels at grid cell (x,y) on an 8-bit 8080-style LCD bus (wr/dcx/D).
- Runs an optional panel-init sequence on request.
- Sits between the game-state scanner and the LCD pins; it owns the command sequencing, the RGB565 palette lookup and the write-strobe timing.

Parameters:
- GRID_BITS, 4, width of the x and y grid coordinates.
- TILE_PX, 16, tile side in pixels; power of two, 2..64.
- WR_DIV, 2, clk cycles per wr phase (low phase, then high phase); minimum 1.
- INIT_WAIT, 1024, idle clk cycles after SWRESET and after SLPOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- init  in  1  pulse; start the panel-init sequence.
- start  in  1  pulse; draw one tile.
- x  in  GRID_BITS  tile column.
- y  in  GRID_BITS  tile row.
- obj_code  in  3  palette index.
- busy  out  1  high while a sequence is running.
- done  out  1  one-cycle pulse at the end of a sequence.
- wr  out  1  LCD write strobe, active low.
- dcx  out  1  0 = command byte, 1 = data byte.
- D  out  8  LCD data bus.

Behaviour:
- Reset state (asynchronous, active-high): wr=1, dcx=1, D=0x00, busy=0, done=0, FSM=IDLE, all counters 0.
- Accept rule: init or start is accepted only in IDLE.
  - If both are high in the same cycle, init is taken and start is dropped.
  - Requests that arrive while busy are ignored. They are not queued.
- On accept: x, y and obj_code are latched; busy goes high on the next cycle.
- Byte transfer: D and dcx change only while wr=1.
  - wr is driven low for WR_DIV cycles, then high for WR_DIV cycles.
  - The LCD samples on the rising edge of wr.
  - Each byte takes 2*WR_DIV cycles; consecutive bytes follow back to back.
- Init sequence, in order:
  - 0x01 (cmd), then INIT_WAIT cycles with wr=1.
  - 0x11 (cmd), then INIT_WAIT cycles.
  - 0x3A (cmd), 0x55 (data).
  - 0x29 (cmd).
- Tile sequence:
  - xs = x*TILE_PX and xe = xs+TILE_PX-1, both 16-bit and zero-extended. ys and ye are formed the same way from y.
  - 0x2A (cmd), then xs[15:8], xs[7:0], xe[15:8], xe[7:0] (data).
  - 0x2B (cmd), then ys/ye bytes in the same order.
  - 0x2C (cmd), then TILE_PX*TILE_PX pixels, each sent as colour[15:8] then colour[7:0] (data).
- Palette (RGB565):
  - 0=0x0000, 1=0xFFFF, 2=0xF800, 3=0x07E0
  - 4=0x001F, 5=0xFFE0, 6=0x07FF, 7=0xF81F
- FSM states:
  - IDLE -> LOAD (latch inputs, select sequence) -> BYTE_LO (wr=0) -> BYTE_HI (wr=1).
  - From BYTE_HI: next byte goes to BYTE_LO; after SWRESET or SLPOUT go to DELAY; after the last byte go to FIN.
  - DELAY -> BYTE_LO once INIT_WAIT cycles have elapsed.
  - FIN: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- Pixel counter: width 2*log2(TILE_PX)+1; terminal count TILE_PX*TILE_PX-1 with no wrap. It is cleared in LOAD.
- Coordinate edge case: x=y=all-ones with TILE_PX=16 and GRID_BITS=4 gives xe=0x00FF. There is no overflow for any legal parameter set.
- Reset mid-sequence: the bus is abandoned and returns to reset values immediately. There is no resume; the next start restarts from 0x2A.
- Bus idle state: D holds the last byte and dcx holds its last value; wr=1.

Optional Feature:
- Macro: TILE_BORDER_EN.
- With the macro defined: pixels on tile row 0, row TILE_PX-1, column 0 or column TILE_PX-1 are sent as 0x0000 (black). Interior pixels use the palette colour. Byte count and timing are unchanged.
- Without the macro: every pixel uses the palette colour.

Test Plan:
- Reset: assert rst mid-tile -> on the same edge wr=1, dcx=1, D=0x00, busy=0. After release, start draws a complete tile from 0x2A.
- Tile at TILE_PX=4, WR_DIV=1, x=2, y=1, obj=2 -> bytes 2A,00,08,00,0B,2B,00,04,00,07,2C then 16 pixels x (F8,00).
  - 43 wr rising edges; dcx=0 on exactly 3 of them.
  - done pulses once, 86 cycles after busy rises.
- Init at INIT_WAIT=8, WR_DIV=1 -> 01, 8-cycle gap, 11, 8-cycle gap, 3A, 55(dcx=1), 29, then done. A start during the gaps has no effect.
- Simultaneous init+start in IDLE -> only the init sequence runs; no 0x2A byte appears before done.
- Max coordinate at TILE_PX=16, x=y=15, obj=7 -> xs/xe bytes 00,F0,00,FF; pixels F8,1F. Pixel count is exactly 256.
- Defined TILE_BORDER_EN, TILE_PX=4, obj=1 -> pixel order (row-major) 0000 x4, 0000,FFFF,FFFF,0000 x2, 0000 x4.
